// File: rtl/fifo_protocol_checker_if.sv
// Monitor bundle for NUM_CH FIFOs: requests, combinational flags and registered strobes.
// The FIFO side drives it through master; the checker samples it through slave.
interface fifo_protocol_checker_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] mon_wr_en;
    logic [NUM_CH-1:0] mon_rd_en;
    logic [NUM_CH-1:0] mon_full;
    logic [NUM_CH-1:0] mon_empty;
    logic [NUM_CH-1:0] mon_almostfull;
    logic [NUM_CH-1:0] mon_almostempty;
    logic [NUM_CH-1:0] mon_wr_ack;
    logic [NUM_CH-1:0] mon_overflow;
    logic [NUM_CH-1:0] mon_underflow;

    modport master (
        output mon_wr_en, mon_rd_en, mon_full, mon_empty, mon_almostfull,
               mon_almostempty, mon_wr_ack, mon_overflow, mon_underflow
    );

    modport slave (
        input  mon_wr_en, mon_rd_en, mon_full, mon_empty, mon_almostfull,
               mon_almostempty, mon_wr_ack, mon_overflow, mon_underflow
    );
endinterface

// File: rtl/fifo_protocol_checker.sv
// Multi-channel FIFO protocol checker: shadow occupancy model per channel, flag/strobe
// checks against it, saturating statistics, sticky error flags and first-error capture.
module fifo_protocol_checker #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    fifo_protocol_checker_if.slave mon,
    input  logic [CH_W-1:0]       sel,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [OCC_W-1:0]      occ,
    output logic [NUM_CH-1:0]     err_flags,
    output logic                  first_err_vld,
    output logic [CH_W-1:0]       first_err_ch,
    output logic [6:0]            first_err_code
);

    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_AFULL = OCC_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [NUM_CH-1:0][OCC_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            p_wa_q, p_wa_d, p_ovf_q, p_ovf_d, p_udf_q, p_udf_d;
    logic [NUM_CH-1:0][CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0]            err_flags_q, err_flags_d;
    logic                         first_err_vld_q, first_err_vld_d;
    logic [CH_W-1:0]              first_err_ch_q, first_err_ch_d;
    logic [6:0]                   first_err_code_q, first_err_code_d;

    logic [NUM_CH-1:0]            wa, ra, err_hit;
    logic [NUM_CH-1:0][6:0]       code;

    // Shadow model: a request is accepted only if the FIFO can honour it, so c never wraps.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wa      = '0;
        ra      = '0;
        cnt_d   = cnt_q;
        p_wa_d  = '0;
        p_ovf_d = '0;
        p_udf_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wa[ch]      = mon.mon_wr_en[ch] && (cnt_q[ch] != OCC_FULL);
            ra[ch]      = mon.mon_rd_en[ch] && (cnt_q[ch] != '0);
            p_wa_d[ch]  = wa[ch];
            p_ovf_d[ch] = mon.mon_wr_en[ch] && !wa[ch];
            p_udf_d[ch] = mon.mon_rd_en[ch] && !ra[ch];
            case ({wa[ch], ra[ch]})
                2'b10:   cnt_d[ch] = cnt_q[ch] + OCC_ONE;
                2'b01:   cnt_d[ch] = cnt_q[ch] - OCC_ONE;
                default: cnt_d[ch] = cnt_q[ch];
            endcase
        end
    end

    always_comb begin
        code    = '0;
        err_hit = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            code[ch][0] = mon.mon_full[ch]        != (cnt_q[ch] == OCC_FULL);
            code[ch][1] = mon.mon_empty[ch]       != (cnt_q[ch] == '0);
            code[ch][2] = mon.mon_almostfull[ch]  != (cnt_q[ch] == OCC_AFULL);
            code[ch][3] = mon.mon_almostempty[ch] != (cnt_q[ch] == OCC_ONE);
            code[ch][4] = mon.mon_wr_ack[ch]      != p_wa_q[ch];
            code[ch][5] = mon.mon_overflow[ch]    != p_ovf_q[ch];
            code[ch][6] = mon.mon_underflow[ch]   != p_udf_q[ch];
            err_hit[ch] = |code[ch];
        end
    end

    // Statistics and error capture; clr wins over a same-cycle error.
    always_comb begin
        wr_cnt_d         = wr_cnt_q;
        rd_cnt_d         = rd_cnt_q;
        err_cnt_d        = err_cnt_q;
        err_flags_d      = err_flags_q;
        first_err_vld_d  = first_err_vld_q;
        first_err_ch_d   = first_err_ch_q;
        first_err_code_d = first_err_code_q;
        if (clr) begin
            wr_cnt_d         = '0;
            rd_cnt_d         = '0;
            err_cnt_d        = '0;
            err_flags_d      = '0;
            first_err_vld_d  = 1'b0;
            first_err_ch_d   = '0;
            first_err_code_d = '0;
        end else if (en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wa[ch] && wr_cnt_q[ch] != CNT_MAX)       wr_cnt_d[ch]  = wr_cnt_q[ch] + CNT_W'(1);
                if (ra[ch] && rd_cnt_q[ch] != CNT_MAX)       rd_cnt_d[ch]  = rd_cnt_q[ch] + CNT_W'(1);
                if (err_hit[ch] && err_cnt_q[ch] != CNT_MAX) err_cnt_d[ch] = err_cnt_q[ch] + CNT_W'(1);
            end
            err_flags_d = err_flags_q | err_hit;
            if (!first_err_vld_q && (|err_hit)) begin
                first_err_vld_d = 1'b1;
                // Descending scan so the lowest failing channel is the last, winning, write.
                for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
                    if (err_hit[ch]) begin
                        first_err_ch_d   = CH_W'(ch);
                        first_err_code_d = code[ch];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            cnt_q            <= '0;
            p_wa_q           <= '0;
            p_ovf_q          <= '0;
            p_udf_q          <= '0;
            wr_cnt_q         <= '0;
            rd_cnt_q         <= '0;
            err_cnt_q        <= '0;
            err_flags_q      <= '0;
            first_err_vld_q  <= 1'b0;
            first_err_ch_q   <= '0;
            first_err_code_q <= '0;
        end else begin
            cnt_q            <= cnt_d;
            p_wa_q           <= p_wa_d;
            p_ovf_q          <= p_ovf_d;
            p_udf_q          <= p_udf_d;
            wr_cnt_q         <= wr_cnt_d;
            rd_cnt_q         <= rd_cnt_d;
            err_cnt_q        <= err_cnt_d;
            err_flags_q      <= err_flags_d;
            first_err_vld_q  <= first_err_vld_d;
            first_err_ch_q   <= first_err_ch_d;
            first_err_code_q <= first_err_code_d;
        end
    end

    // Compare against each channel index so an out-of-range sel simply matches nothing.
    always_comb begin
        wr_cnt  = '0;
        rd_cnt  = '0;
        err_cnt = '0;
        occ     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel == CH_W'(ch)) begin
                wr_cnt  = wr_cnt_q[ch];
                rd_cnt  = rd_cnt_q[ch];
                err_cnt = err_cnt_q[ch];
                occ     = cnt_q[ch];
            end
        end
    end

    assign err_flags      = err_flags_q;
    assign first_err_vld  = first_err_vld_q;
    assign first_err_ch   = first_err_ch_q;
    assign first_err_code = first_err_code_q;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Directed bench for fifo_protocol_checker (2 channels, depth 8, 4-bit counters, 2-bit sel).
// Flags are generated from a bench-side occupancy tracker; injected faults are overrides.
module tb_fifo_protocol_checker;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;
    localparam int OCC_W  = 4;

    logic              clk = 1'b0;
    logic              rst, en, clr;
    logic [CH_W-1:0]   sel;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt, err_cnt;
    logic [OCC_W-1:0]  occ;
    logic [NUM_CH-1:0] err_flags;
    logic              first_err_vld;
    logic [CH_W-1:0]   first_err_ch;
    logic [6:0]        first_err_code;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          tb_c [NUM_CH];
    logic [1:0]  tb_pwa, tb_povf, tb_pudf;

    fifo_protocol_checker_if #(.NUM_CH(NUM_CH)) mon_if ();

    fifo_protocol_checker #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .CH_W(CH_W), .OCC_W(OCC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr           (clr),
        .mon           (mon_if.slave),
        .sel           (sel),
        .wr_cnt        (wr_cnt),
        .rd_cnt        (rd_cnt),
        .err_cnt       (err_cnt),
        .occ           (occ),
        .err_flags     (err_flags),
        .first_err_vld (first_err_vld),
        .first_err_ch  (first_err_ch),
        .first_err_code(first_err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic good_flags();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            mon_if.mon_full[ch]        = (tb_c[ch] == DEPTH);
            mon_if.mon_empty[ch]       = (tb_c[ch] == 0);
            mon_if.mon_almostfull[ch]  = (tb_c[ch] == DEPTH - 1);
            mon_if.mon_almostempty[ch] = (tb_c[ch] == 1);
            mon_if.mon_wr_ack[ch]      = tb_pwa[ch];
            mon_if.mon_overflow[ch]    = tb_povf[ch];
            mon_if.mon_underflow[ch]   = tb_pudf[ch];
        end
    endtask

    task automatic apply(input logic [1:0] wr, input logic [1:0] rd);
        mon_if.mon_wr_en = wr;
        mon_if.mon_rd_en = rd;
        good_flags();
    endtask

    task automatic tick();
        logic wa, ra;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wa = mon_if.mon_wr_en[ch] && (tb_c[ch] < DEPTH);
            ra = mon_if.mon_rd_en[ch] && (tb_c[ch] > 0);
            tb_pwa[ch]  = wa;
            tb_povf[ch] = mon_if.mon_wr_en[ch] && !wa;
            tb_pudf[ch] = mon_if.mon_rd_en[ch] && !ra;
            tb_c[ch]    = tb_c[ch] + int'(wa) - int'(ra);
        end
    endtask

    task automatic view(input int ch);
        sel = CH_W'(ch);
        #1;
    endtask

    initial begin
        // Reset with random inputs on every pin.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en  = 1'($urandom);
            clr = 1'($urandom);
            sel = CH_W'($urandom);
            mon_if.mon_wr_en       = 2'($urandom);
            mon_if.mon_rd_en       = 2'($urandom);
            mon_if.mon_full        = 2'($urandom);
            mon_if.mon_empty       = 2'($urandom);
            mon_if.mon_almostfull  = 2'($urandom);
            mon_if.mon_almostempty = 2'($urandom);
            mon_if.mon_wr_ack      = 2'($urandom);
            mon_if.mon_overflow    = 2'($urandom);
            mon_if.mon_underflow   = 2'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        tb_c = '{0, 0};
        tb_pwa = '0; tb_povf = '0; tb_pudf = '0;
        apply(2'b00, 2'b00);
        view(0);
        check("rst_occ0", occ, 0);
        check("rst_wr0", wr_cnt, 0);
        check("rst_rd0", rd_cnt, 0);
        check("rst_err0", err_cnt, 0);
        check("rst_flags", err_flags, 0);
        check("rst_fvld", first_err_vld, 0);
        check("rst_fch", first_err_ch, 0);
        check("rst_fcode", first_err_code, 0);
        view(1);
        check("rst_occ1", occ, 0);
        check("rst_wr1", wr_cnt, 0);

        // ch0: fill to DEPTH, then a rejected 9th write.
        for (int i = 0; i < 8; i++) begin
            apply(2'b01, 2'b00);
            tick();
        end
        view(0);
        check("fill_occ", occ, 8);
        check("fill_wr", wr_cnt, 8);
        apply(2'b01, 2'b00);
        tick();
        check("ovf_wr_hold", wr_cnt, 8);
        check("ovf_occ_hold", occ, 8);
        apply(2'b00, 2'b00);
        tick();
        check("ovf_ok_flags", err_flags, 0);
        check("ovf_ok_fvld", first_err_vld, 0);
        apply(2'b01, 2'b00);
        tick();
        apply(2'b00, 2'b00);
        mon_if.mon_overflow[0] = 1'b0;
        tick();
        check("ovf_miss_flags", err_flags, 2'b01);
        check("ovf_miss_fvld", first_err_vld, 1);
        check("ovf_miss_fch", first_err_ch, 0);
        check("ovf_miss_code", first_err_code, 7'b0100000);
        check("ovf_miss_errcnt", err_cnt, 1);

        // ch1: simultaneous requests at empty and at full.
        apply(2'b10, 2'b10);
        tick();
        view(1);
        check("c0_both_occ", occ, 1);
        check("c0_both_wr", wr_cnt, 1);
        check("c0_both_rd", rd_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            apply(2'b10, 2'b00);
            tick();
        end
        check("c1_full_occ", occ, 8);
        apply(2'b10, 2'b10);
        tick();
        check("cf_both_occ", occ, 7);
        check("cf_both_rd", rd_cnt, 1);
        check("cf_both_wr", wr_cnt, 8);
        check("cf_both_err", err_cnt, 0);

        // clr with a coincident error: the error is discarded.
        apply(2'b00, 2'b00);
        mon_if.mon_full[0] = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_flags", err_flags, 0);
        check("clr_fvld", first_err_vld, 0);
        check("clr_wr1", wr_cnt, 0);

        // Both channels report a wrong empty in the same cycle.
        apply(2'b00, 2'b00);
        mon_if.mon_empty = ~mon_if.mon_empty;
        tick();
        view(0);
        check("dual_err0", err_cnt, 1);
        view(1);
        check("dual_err1", err_cnt, 1);
        check("dual_flags", err_flags, 2'b11);
        check("dual_fch", first_err_ch, 0);
        check("dual_code", first_err_code, 7'b0000010);

        // Saturation of err_cnt on ch0, then clr.
        for (int i = 0; i < 20; i++) begin
            apply(2'b00, 2'b00);
            mon_if.mon_full[0] = 1'b0;
            tick();
        end
        view(0);
        check("sat_err", err_cnt, 15);
        check("sat_code_held", first_err_code, 7'b0000010);
        apply(2'b00, 2'b00);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr_err", err_cnt, 0);
        check("sat_clr_flags", err_flags, 0);
        check("sat_clr_fvld", first_err_vld, 0);
        check("sat_clr_occ0", occ, 8);
        view(1);
        check("sat_clr_occ1", occ, 7);

        // Drain ch0 and read once more at empty: underflow strobe expected next cycle.
        for (int i = 0; i < 8; i++) begin
            apply(2'b00, 2'b01);
            tick();
        end
        view(0);
        check("drain_occ", occ, 0);
        check("drain_rd", rd_cnt, 8);
        apply(2'b00, 2'b01);
        tick();
        check("udf_rd_hold", rd_cnt, 8);
        apply(2'b00, 2'b00);
        tick();
        check("udf_ok_flags", err_flags, 0);

        // en=0: three writes with a bad full flag; nothing is counted or flagged.
        apply(2'b00, 2'b00);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, 2'b00);
            mon_if.mon_full[0] = 1'b1;
            tick();
        end
        en = 1'b1;
        apply(2'b00, 2'b00);
        tick();
        check("en0_wr", wr_cnt, 0);
        check("en0_occ", occ, 3);
        check("en0_flags", err_flags, 0);
        check("en0_err", err_cnt, 0);

        // Out-of-range select.
        view(3);
        check("sel3_wr", wr_cnt, 0);
        check("sel3_rd", rd_cnt, 0);
        check("sel3_err", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_protocol_checker.md
Name: fifo_protocol_checker

Overview:
- Synthesizable, multi-channel successor to our testbench FIFO monitor.
- Watches the handshake and flag pins of NUM_CH independent synchronous FIFOs and keeps a shadow occupancy model for each one.
- Every cycle it checks full/empty/almost flags and the registered strobes against that model, and keeps saturating statistics per channel.
- Sits beside the FIFOs in the DUT/emulation build. Firmware or the bench reads the statistics through a channel-select port.

Parameters:
- NUM_CH, 4: number of monitored FIFOs. Range 1..16.
- DEPTH, 8: depth of every monitored FIFO. Must be ≥2.
- CNT_W, 16: width of the statistics counters.
- CH_W, $clog2(NUM_CH) (min 1): width of channel indices.
- OCC_W, $clog2(DEPTH+1): width of the occupancy value.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enables checking and statistics. The shadow model always tracks, whatever en is.
- clr  in  1  synchronous clear of statistics and error capture.
- mon_wr_en  in  NUM_CH  per-channel write request.
- mon_rd_en  in  NUM_CH  per-channel read request.
- mon_full, mon_empty, mon_almostfull, mon_almostempty  in  NUM_CH each  combinational FIFO flags.
- mon_wr_ack, mon_overflow, mon_underflow  in  NUM_CH each  registered FIFO strobes.
- sel  in  CH_W  channel selected for the read port.
- wr_cnt, rd_cnt, err_cnt  out  CNT_W each  statistics of channel sel.
- occ  out  OCC_W  shadow occupancy of channel sel.
- err_flags  out  NUM_CH  sticky per-channel mismatch flags.
- first_err_vld  out  1  a first error has been captured.
- first_err_ch  out  CH_W  channel of the first error.
- first_err_code  out  7  failing-check mask of the first error.

Behaviour:
- Reset: every counter, shadow count, prev-strobe register, err_flags, first_err_* and occ is 0 one cycle after rst is sampled high. rst has priority over clr.
- Shadow model, per channel, with count c:
  - wa = wr_en & (c<DEPTH); ra = rd_en & (c>0).
  - c==0 with both requests: write only. c==DEPTH with both requests: read only. Otherwise both requests leave c unchanged.
  - c_next = c + wa - ra. c never wraps.
- Previous-cycle registers: p_wa = wa, p_ovf = wr_en & ~wa, p_udf = rd_en & ~ra.
- Checks, evaluated in cycle N only when en=1. Each mismatch sets one bit of the 7-bit code:
  - bit0: full ≠ (c==DEPTH)
  - bit1: empty ≠ (c==0)
  - bit2: almostfull ≠ (c==DEPTH-1)
  - bit3: almostempty ≠ (c==1)
  - bit4: wr_ack ≠ p_wa
  - bit5: overflow ≠ p_ovf
  - bit6: underflow ≠ p_udf
- Statistics, updated only when en=1, visible the cycle after the sampled edge:
  - wr_cnt increments on wa; rd_cnt increments on ra.
  - err_cnt increments by 1 per channel-cycle with a nonzero code, not per bit.
  - All counters saturate at 2^CNT_W-1.
- Sticky flags: err_flags[ch] sets on any nonzero code and holds until clr/rst.
- First-error capture:
  - Records on the first nonzero code after rst/clr.
  - When several channels fail in the same cycle, the lowest index wins.
  - first_err_* hold until clr/rst.
- clr:
  - Zeroes wr/rd/err counters, err_flags and first_err_*.
  - Does not touch the shadow counts or prev-strobe registers.
  - An error in the same cycle as clr is discarded.
- en=0: checks and statistics are frozen; the shadow model and prev registers keep updating.
- Read port: combinational mux over registered state by sel. sel ≥ NUM_CH drives all stat outputs to 0.

Test Plan (NUM_CH=2, DEPTH=8, CNT_W=4):
- rst=1 for 2 cycles with random inputs → all outputs 0, occ=0 on both channels.
- ch0: 8 writes with matching flags, then a 9th write → occ=8, wr_cnt=8; mon_overflow=1 next cycle gives no error; mon_overflow=0 next cycle gives err_flags[0]=1, first_err_code=7'b0100000.
- ch1: simultaneous wr_en=rd_en=1 at c=0 → occ=1, wr_cnt=1, rd_cnt=0. At c=8 → occ=7, rd_cnt increments.
- Both channels drive a wrong mon_empty in the same cycle → err_cnt=1 on each channel, first_err_ch=0, code=7'b0000010.
- 20 erroneous cycles on ch0 → err_cnt saturates at 15. clr then gives err_cnt=0, err_flags=0, first_err_vld=0, occ unchanged.
- en=0 for 3 writes then en=1 → wr_cnt unchanged, occ=3, no false flag errors afterwards. sel=3 → all stats read as 0.
